// File: rtl/sram_port_arbiter.sv
// Two-requester arbiter sharing a 1R1W scratchpad SRAM with independent round-robin write and read ports.
// Reads that would hit an in-flight write are stalled; define SRAM_ARB_FWD_EN to forward write data instead.
module sram_port_arbiter #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 16
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic [1:0]              req_valid,
   output logic [1:0]              req_ready,
   input  logic [1:0]              req_write,
   input  logic [2*ADDR_WIDTH-1:0] req_addr,
   input  logic [2*DATA_WIDTH-1:0] req_wdata,
   output logic [1:0]              rsp_valid,
   output logic [DATA_WIDTH-1:0]   rsp_data,
   output logic [ADDR_WIDTH-1:0]   sram_write_address,
   output logic [DATA_WIDTH-1:0]   sram_write_data,
   output logic                    sram_write_enable,
   output logic [ADDR_WIDTH-1:0]   sram_read_address,
   input  logic [DATA_WIDTH-1:0]   sram_read_data
);

   logic                  wr_ptr_reg, wr_ptr_next;
   logic                  rd_ptr_reg, rd_ptr_next;
   logic                  hz_valid_reg, hz_valid_next;
   logic [ADDR_WIDTH-1:0] hz_addr_reg, hz_addr_next;
   logic                  rsp_owner_reg, rsp_owner_next;
   logic                  rsp_owner_valid_reg, rsp_owner_valid_next;

   logic [ADDR_WIDTH-1:0] addr  [2];
   logic [DATA_WIDTH-1:0] wdata [2];
   logic [1:0]            wr_cand;
   logic [1:0]            rd_cand;
   logic [1:0]            hazard;
   logic                  wr_grant, wr_win;
   logic                  rd_grant, rd_win;

   // Two candidates go to the pointer; otherwise the single candidate wins.
   function automatic logic pick(input logic [1:0] cand, input logic ptr);
      return (cand == 2'b11) ? ptr : cand[1];
   endfunction

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_req
         assign addr[gi]    = req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
         assign wdata[gi]   = req_wdata[gi*DATA_WIDTH +: DATA_WIDTH];
         assign wr_cand[gi] = reset & req_valid[gi] & req_write[gi];
         assign hazard[gi]  = (wr_grant && (addr[gi] == sram_write_address)) ||
                              (hz_valid_reg && (addr[gi] == hz_addr_reg));
`ifdef SRAM_ARB_FWD_EN
         assign rd_cand[gi] = reset & req_valid[gi] & ~req_write[gi];
`else
         assign rd_cand[gi] = reset & req_valid[gi] & ~req_write[gi] & ~hazard[gi];
`endif
         assign req_ready[gi] = (wr_grant && (wr_win == 1'(gi))) ||
                                (rd_grant && (rd_win == 1'(gi)));
         assign rsp_valid[gi] = reset & rsp_owner_valid_reg & (rsp_owner_reg == 1'(gi));
      end
   endgenerate

   assign wr_grant = |wr_cand;
   assign wr_win   = pick(wr_cand, wr_ptr_reg);
   assign rd_grant = |rd_cand;
   assign rd_win   = pick(rd_cand, rd_ptr_reg);

   assign sram_write_enable  = wr_grant;
   assign sram_write_address = wr_grant ? addr[wr_win]  : '0;
   assign sram_write_data    = wr_grant ? wdata[wr_win] : '0;
   assign sram_read_address  = rd_grant ? addr[rd_win]  : '0;

   always_comb begin
      wr_ptr_next          = wr_ptr_reg;
      rd_ptr_next          = rd_ptr_reg;
      rsp_owner_next       = rsp_owner_reg;
      hz_valid_next        = wr_grant;
      hz_addr_next         = sram_write_address;
      rsp_owner_valid_next = rd_grant;
      if (wr_grant) begin
         wr_ptr_next = ~wr_win;
      end
      if (rd_grant) begin
         rd_ptr_next    = ~rd_win;
         rsp_owner_next = rd_win;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         wr_ptr_reg          <= 1'b0;
         rd_ptr_reg          <= 1'b0;
         hz_valid_reg        <= 1'b0;
         hz_addr_reg         <= '0;
         rsp_owner_reg       <= 1'b0;
         rsp_owner_valid_reg <= 1'b0;
      end else begin
         wr_ptr_reg          <= wr_ptr_next;
         rd_ptr_reg          <= rd_ptr_next;
         hz_valid_reg        <= hz_valid_next;
         hz_addr_reg         <= hz_addr_next;
         rsp_owner_reg       <= rsp_owner_next;
         rsp_owner_valid_reg <= rsp_owner_valid_next;
      end
   end

`ifdef SRAM_ARB_FWD_EN
   logic [DATA_WIDTH-1:0] hz_data_reg, hz_data_next;
   logic [DATA_WIDTH-1:0] fwd_data_reg, fwd_data_next;
   logic                  fwd_sel_reg, fwd_sel_next;

   // The write granted this cycle is newer than the one in the hazard window, so it takes priority.
   always_comb begin
      hz_data_next  = sram_write_data;
      fwd_sel_next  = rd_grant & hazard[rd_win];
      fwd_data_next = hz_data_reg;
      if (wr_grant && (addr[rd_win] == sram_write_address)) begin
         fwd_data_next = sram_write_data;
      end
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         hz_data_reg  <= '0;
         fwd_data_reg <= '0;
         fwd_sel_reg  <= 1'b0;
      end else begin
         hz_data_reg  <= hz_data_next;
         fwd_data_reg <= fwd_data_next;
         fwd_sel_reg  <= fwd_sel_next;
      end
   end

   assign rsp_data = fwd_sel_reg ? fwd_data_reg : sram_read_data;
`else
   assign rsp_data = sram_read_data;
`endif

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter with a 1R1W SRAM model that returns X on read-after-recent-write.
// Build with SRAM_ARB_FWD_EN defined to exercise the forwarding variant.
module tb_sram_port_arbiter;

   logic        clock;
   logic        reset;
   logic [1:0]  req_valid;
   logic [1:0]  req_ready;
   logic [1:0]  req_write;
   logic [63:0] req_addr;
   logic [31:0] req_wdata;
   logic [1:0]  rsp_valid;
   logic [15:0] rsp_data;
   logic [31:0] sram_write_address;
   logic [15:0] sram_write_data;
   logic        sram_write_enable;
   logic [31:0] sram_read_address;
   logic [15:0] sram_read_data;

   int checks   = 0;
   int failures = 0;

   sram_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(16)) dut (
      .clock              (clock),
      .reset              (reset),
      .req_valid          (req_valid),
      .req_ready          (req_ready),
      .req_write          (req_write),
      .req_addr           (req_addr),
      .req_wdata          (req_wdata),
      .rsp_valid          (rsp_valid),
      .rsp_data           (rsp_data),
      .sram_write_address (sram_write_address),
      .sram_write_data    (sram_write_data),
      .sram_write_enable  (sram_write_enable),
      .sram_read_address  (sram_read_address),
      .sram_read_data     (sram_read_data)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // SRAM model: unwritten locations hold a pattern, 0x40 is preloaded with 0xBEEF.
   logic [15:0] mem [256];
   bit   [255:0] written;
   bit          last_we;
   bit   [31:0] last_wa;

   function automatic logic [15:0] init_val(input logic [7:0] a);
      return (a == 8'h40) ? 16'hBEEF : {8'hD0, a};
   endfunction

   always @(posedge clock) begin
      if (sram_write_enable) begin
         mem[sram_write_address[7:0]]     <= sram_write_data;
         written[sram_write_address[7:0]] <= 1'b1;
      end
      if ((last_we && sram_read_address == last_wa) ||
          (sram_write_enable && sram_read_address == sram_write_address))
         sram_read_data <= 'x;
      else
         sram_read_data <= written[sram_read_address[7:0]] ? mem[sram_read_address[7:0]]
                                                           : init_val(sram_read_address[7:0]);
      last_we <= sram_write_enable;
      last_wa <= sram_write_address;
   end

   task automatic drive(input logic [1:0] v, input logic [1:0] w, input logic [31:0] a0,
                        input logic [31:0] a1, input logic [15:0] d0, input logic [15:0] d1);
      req_valid = v;
      req_write = w;
      req_addr  = {a1, a0};
      req_wdata = {d1, d0};
   endtask

   task automatic next_cycle();
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      drive(2'b00, 2'b00, 0, 0, 0, 0);
      next_cycle();
      next_cycle();
      reset = 1'b1;
   endtask

   task automatic test_reset();
      reset = 1'b0;
      drive(2'b11, 2'b11, 32'h10, 32'h20, 16'hAAAA, 16'h5555);
      for (int k = 0; k < 3; k++) begin
         @(negedge clock);
         $display("reset cyc=%0d ready=%b we=%b rsp_valid=%b", k, req_ready, sram_write_enable, rsp_valid);
         checks++; if (req_ready !== 2'b00) begin failures++; $display("FAIL rst_ready got=%b exp=00", req_ready); end
         checks++; if (sram_write_enable !== 1'b0) begin failures++; $display("FAIL rst_we got=%b exp=0", sram_write_enable); end
         checks++; if (rsp_valid !== 2'b00) begin failures++; $display("FAIL rst_rsp got=%b exp=00", rsp_valid); end
         next_cycle();
      end
      reset = 1'b1;
      drive(2'b11, 2'b00, 32'h1, 32'h2, 0, 0);
      @(negedge clock);
      $display("reset post-release read ready=%b ra=%h", req_ready, sram_read_address);
      checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL rst_rdptr got=%b exp=01", req_ready); end
      checks++; if (sram_read_address !== 32'h1) begin failures++; $display("FAIL rst_ra got=%h exp=00000001", sram_read_address); end
      next_cycle();
      drive(2'b00, 2'b00, 0, 0, 0, 0);
      @(negedge clock);
      $display("reset post-release rsp valid=%b data=%h", rsp_valid, rsp_data);
      checks++; if (rsp_valid !== 2'b01) begin failures++; $display("FAIL rst_rsp_valid got=%b exp=01", rsp_valid); end
      checks++; if (rsp_data !== 16'hD001) begin failures++; $display("FAIL rst_rsp_data got=%h exp=d001", rsp_data); end
      next_cycle();
   endtask

   task automatic test_write_contention();
      logic [1:0]  er;
      logic [31:0] ea;
      logic [15:0] ed;
      do_reset();
      drive(2'b11, 2'b11, 32'h10, 32'h20, 16'hAAAA, 16'h5555);
      for (int k = 0; k < 4; k++) begin
         er = (k % 2 == 0) ? 2'b01 : 2'b10;
         ea = (k % 2 == 0) ? 32'h10 : 32'h20;
         ed = (k % 2 == 0) ? 16'hAAAA : 16'h5555;
         @(negedge clock);
         $display("wr_cont cyc=%0d ready=%b we=%b wa=%h wd=%h", k, req_ready, sram_write_enable, sram_write_address, sram_write_data);
         checks++; if (req_ready !== er) begin failures++; $display("FAIL wr_ready cyc=%0d got=%b exp=%b", k, req_ready, er); end
         checks++; if (sram_write_enable !== 1'b1) begin failures++; $display("FAIL wr_we cyc=%0d got=%b exp=1", k, sram_write_enable); end
         checks++; if (sram_write_address !== ea) begin failures++; $display("FAIL wr_addr cyc=%0d got=%h exp=%h", k, sram_write_address, ea); end
         checks++; if (sram_write_data !== ed) begin failures++; $display("FAIL wr_data cyc=%0d got=%h exp=%h", k, sram_write_data, ed); end
         next_cycle();
      end
      drive(2'b00, 2'b00, 0, 0, 0, 0);
   endtask

   task automatic test_parallel_rw();
      do_reset();
      drive(2'b11, 2'b01, 32'h30, 32'h40, 16'h1234, 16'h0);
      @(negedge clock);
      $display("par_rw accept ready=%b we=%b wa=%h ra=%h", req_ready, sram_write_enable, sram_write_address, sram_read_address);
      checks++; if (req_ready !== 2'b11) begin failures++; $display("FAIL par_ready got=%b exp=11", req_ready); end
      checks++; if (sram_read_address !== 32'h40) begin failures++; $display("FAIL par_ra got=%h exp=00000040", sram_read_address); end
      checks++; if (rsp_valid !== 2'b00) begin failures++; $display("FAIL par_rsp_early got=%b exp=00", rsp_valid); end
      next_cycle();
      drive(2'b00, 2'b00, 0, 0, 0, 0);
      @(negedge clock);
      $display("par_rw rsp valid=%b data=%h", rsp_valid, rsp_data);
      checks++; if (rsp_valid !== 2'b10) begin failures++; $display("FAIL par_rsp_valid got=%b exp=10", rsp_valid); end
      checks++; if (rsp_data !== 16'hBEEF) begin failures++; $display("FAIL par_rsp_data got=%h exp=beef", rsp_data); end
      next_cycle();
   endtask

   task automatic test_raw_stall();
      do_reset();
      drive(2'b11, 2'b01, 32'h50, 32'h50, 16'hCAFE, 16'h0);
      @(negedge clock);
      $display("raw t ready=%b we=%b wa=%h", req_ready, sram_write_enable, sram_write_address);
`ifdef SRAM_ARB_FWD_EN
      checks++; if (req_ready !== 2'b11) begin failures++; $display("FAIL raw_t_ready got=%b exp=11", req_ready); end
      next_cycle();
      drive(2'b00, 2'b00, 0, 0, 0, 0);
      @(negedge clock);
      $display("raw t+1 rsp valid=%b data=%h", rsp_valid, rsp_data);
      checks++; if (rsp_valid !== 2'b10) begin failures++; $display("FAIL raw_rsp_valid got=%b exp=10", rsp_valid); end
      checks++; if (rsp_data !== 16'hCAFE) begin failures++; $display("FAIL raw_rsp_data got=%h exp=cafe", rsp_data); end
      next_cycle();
`else
      checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL raw_t_ready got=%b exp=01", req_ready); end
      next_cycle();
      drive(2'b10, 2'b00, 0, 32'h50, 0, 0);
      @(negedge clock);
      $display("raw t+1 ready=%b", req_ready);
      checks++; if (req_ready !== 2'b00) begin failures++; $display("FAIL raw_t1_ready got=%b exp=00", req_ready); end
      next_cycle();
      @(negedge clock);
      $display("raw t+2 ready=%b ra=%h", req_ready, sram_read_address);
      checks++; if (req_ready !== 2'b10) begin failures++; $display("FAIL raw_t2_ready got=%b exp=10", req_ready); end
      checks++; if (sram_read_address !== 32'h50) begin failures++; $display("FAIL raw_t2_ra got=%h exp=00000050", sram_read_address); end
      next_cycle();
      drive(2'b00, 2'b00, 0, 0, 0, 0);
      @(negedge clock);
      $display("raw t+3 rsp valid=%b data=%h", rsp_valid, rsp_data);
      checks++; if (rsp_valid !== 2'b10) begin failures++; $display("FAIL raw_rsp_valid got=%b exp=10", rsp_valid); end
      checks++; if (rsp_data !== 16'hCAFE) begin failures++; $display("FAIL raw_rsp_data got=%h exp=cafe", rsp_data); end
      next_cycle();
`endif
   endtask

   task automatic test_hazard_other();
      do_reset();
      drive(2'b01, 2'b01, 32'h60, 0, 16'h7777, 0);
      @(negedge clock);
      $display("hz_other write ready=%b wa=%h", req_ready, sram_write_address);
      checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL hzo_wr_ready got=%b exp=01", req_ready); end
      next_cycle();
      drive(2'b11, 2'b00, 32'h60, 32'h61, 0, 0);
      @(negedge clock);
      $display("hz_other read ready=%b ra=%h", req_ready, sram_read_address);
`ifdef SRAM_ARB_FWD_EN
      checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL hzo_rd_ready got=%b exp=01", req_ready); end
      checks++; if (sram_read_address !== 32'h60) begin failures++; $display("FAIL hzo_ra got=%h exp=00000060", sram_read_address); end
`else
      checks++; if (req_ready !== 2'b10) begin failures++; $display("FAIL hzo_rd_ready got=%b exp=10", req_ready); end
      checks++; if (sram_read_address !== 32'h61) begin failures++; $display("FAIL hzo_ra got=%h exp=00000061", sram_read_address); end
`endif
      next_cycle();
      drive(2'b00, 2'b00, 0, 0, 0, 0);
      @(negedge clock);
      $display("hz_other rsp valid=%b data=%h", rsp_valid, rsp_data);
`ifdef SRAM_ARB_FWD_EN
      checks++; if (rsp_valid !== 2'b01) begin failures++; $display("FAIL hzo_rsp_valid got=%b exp=01", rsp_valid); end
      checks++; if (rsp_data !== 16'h7777) begin failures++; $display("FAIL hzo_rsp_data got=%h exp=7777", rsp_data); end
`else
      checks++; if (rsp_valid !== 2'b10) begin failures++; $display("FAIL hzo_rsp_valid got=%b exp=10", rsp_valid); end
      checks++; if (rsp_data !== 16'hD061) begin failures++; $display("FAIL hzo_rsp_data got=%h exp=d061", rsp_data); end
`endif
      next_cycle();
   endtask

   task automatic test_back_to_back();
      logic [15:0] ed;
      do_reset();
      for (int i = 0; i < 9; i++) begin
         if (i < 8) drive(2'b01, 2'b00, i, 0, 0, 0);
         else       drive(2'b00, 2'b00, 0, 0, 0, 0);
         @(negedge clock);
         $display("stream cyc=%0d ready=%b ra=%h rsp_valid=%b rsp_data=%h", i, req_ready, sram_read_address, rsp_valid, rsp_data);
         if (i < 8) begin
            checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL stream_ready cyc=%0d got=%b exp=01", i, req_ready); end
            checks++; if (sram_read_address !== i) begin failures++; $display("FAIL stream_ra cyc=%0d got=%h exp=%h", i, sram_read_address, i); end
         end
         if (i > 0) begin
            ed = 16'hD000 | 16'(i - 1);
            checks++; if (rsp_valid !== 2'b01) begin failures++; $display("FAIL stream_rsp_valid cyc=%0d got=%b exp=01", i, rsp_valid); end
            checks++; if (rsp_data !== ed) begin failures++; $display("FAIL stream_rsp_data cyc=%0d got=%h exp=%h", i, rsp_data, ed); end
         end
         next_cycle();
      end
      @(negedge clock);
      $display("stream drain rsp_valid=%b", rsp_valid);
      checks++; if (rsp_valid !== 2'b00) begin failures++; $display("FAIL stream_drain got=%b exp=00", rsp_valid); end
      next_cycle();
   endtask

   task automatic test_reset_mid_read();
      do_reset();
      drive(2'b01, 2'b00, 32'h3, 0, 0, 0);
      @(negedge clock);
      $display("mid_rst accept ready=%b", req_ready);
      checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL midrst_ready got=%b exp=01", req_ready); end
      next_cycle();
      reset = 1'b0;
      drive(2'b00, 2'b00, 0, 0, 0, 0);
      @(negedge clock);
      $display("mid_rst during reset rsp_valid=%b", rsp_valid);
      checks++; if (rsp_valid !== 2'b00) begin failures++; $display("FAIL midrst_rsp_in got=%b exp=00", rsp_valid); end
      next_cycle();
      reset = 1'b1;
      @(negedge clock);
      $display("mid_rst after release rsp_valid=%b", rsp_valid);
      checks++; if (rsp_valid !== 2'b00) begin failures++; $display("FAIL midrst_rsp_after got=%b exp=00", rsp_valid); end
      next_cycle();
      drive(2'b01, 2'b00, 32'h4, 0, 0, 0);
      @(negedge clock);
      $display("mid_rst new read ready=%b", req_ready);
      checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL midrst_new_ready got=%b exp=01", req_ready); end
      next_cycle();
      drive(2'b00, 2'b00, 0, 0, 0, 0);
      @(negedge clock);
      $display("mid_rst new rsp valid=%b data=%h", rsp_valid, rsp_data);
      checks++; if (rsp_valid !== 2'b01) begin failures++; $display("FAIL midrst_new_valid got=%b exp=01", rsp_valid); end
      checks++; if (rsp_data !== 16'hD004) begin failures++; $display("FAIL midrst_new_data got=%h exp=d004", rsp_data); end
      next_cycle();
   endtask

   initial begin
      reset = 1'b0;
      drive(2'b00, 2'b00, 0, 0, 0, 0);
      next_cycle();
      test_reset();
      test_write_contention();
      test_parallel_rw();
      test_raw_stall();
      test_hazard_other();
      test_back_to_back();
      test_reset_mid_read();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/sram_port_arbiter.md
Name: sram_port_arbiter

Overview:
- Two-requester arbiter in front of the 1R1W scratchpad SRAM: shares its write and read ports between requester 0 (loader) and requester 1 (compute engine).
- Per cycle, at most one write and one read go to the SRAM. Each port has its own round-robin arbitration.
- The SRAM returns X when a read hits the previous cycle's write. The arbiter prevents this by stalling any read that would hit an in-flight write.
- Read responses are routed back to the requester that issued the read.

Parameters:
- ADDR_WIDTH, 32, SRAM address width
- DATA_WIDTH, 16, SRAM data width

Ports:
- clock  in  1  clock
- reset  in  1  reset, synchronous, active-low
- req_valid  in  2  per-requester request valid, bit i = requester i
- req_ready  out  2  per-requester accept
- req_write  in  2  1 = write, 0 = read
- req_addr  in  2*ADDR_WIDTH  slice i = requester i address
- req_wdata  in  2*DATA_WIDTH  slice i = requester i write data
- rsp_valid  out  2  read data valid for requester i
- rsp_data  out  DATA_WIDTH  read data, shared bus, qualified by rsp_valid
- sram_write_address  out  ADDR_WIDTH
- sram_write_data  out  DATA_WIDTH
- sram_write_enable  out  1
- sram_read_address  out  ADDR_WIDTH
- sram_read_data  in  DATA_WIDTH  registered SRAM output, valid the cycle after the address

Behaviour:
- Reset (reset==0 sampled at posedge):
  - wr_ptr=0, rd_ptr=0, hz_valid=0, rsp_owner_valid=0.
  - Combinational outputs are forced inactive while reset is low: req_ready=0, sram_write_enable=0, rsp_valid=0.
- Handshake:
  - A request is accepted in the cycle where req_valid[i] && req_ready[i].
  - A requester holds req_write/addr/wdata stable while valid and not ready.
  - Each requester has one request per cycle; no ordering between its reads and writes beyond acceptance order.
- Write arbitration (combinational):
  - Candidates are i with req_valid[i] && req_write[i].
  - One candidate: that one wins. Two candidates: the requester at wr_ptr wins.
  - Winner drives sram_write_address/data with sram_write_enable=1.
  - On a grant, wr_ptr <= ~winner.
- Read arbitration:
  - Candidates are i with req_valid[i] && !req_write[i] && !hazard(i).
  - Same round-robin rule with rd_ptr. On a grant, rd_ptr <= ~winner.
  - Winner drives sram_read_address. With no grant, sram_read_address = 0 (never X).
- Hazard rule: hazard(i) = req_addr[i] equals either:
  - the write address granted this cycle, or
  - hz_addr, when hz_valid (write granted last cycle).
- Hazard register update:
  - Every cycle: hz_valid <= write granted; hz_addr <= granted write address.
  - A stalled read can retry the cycle after the conflicting write leaves the window. Maximum added latency is 2 cycles if no new conflicting write arrives.
- Hazard and pointers: a hazard-stalled requester does not advance rd_ptr. The other requester may be granted the read port in that cycle.
- Simultaneous read and write from different requesters: both are granted in the same cycle unless the read hits the hazard rule.
- Response path:
  - Read granted at edge t: rsp_owner <= winner, rsp_owner_valid <= 1.
  - In cycle t+1: rsp_valid[rsp_owner]=1 and rsp_data=sram_read_data.
  - Fixed latency is 1 cycle after acceptance. No backpressure on responses.
  - A new read may be accepted every cycle (fully pipelined).
- Reset mid-operation: any pending response is dropped (rsp_valid=0 on the cycle after reset). The hazard window and pointers clear.
- Widths: all address compares use the full ADDR_WIDTH. There is no arithmetic on addresses.

Optional Feature:
- Macro SRAM_ARB_FWD_EN.
- Defined:
  - Hazard reads are not stalled; they are granted under normal round-robin.
  - The forwarded value is captured into a response-forward register: the write data granted this cycle if the address matches it (priority), else hz_data.
  - In t+1, rsp_data = forward register instead of sram_read_data.
  - hz_data <= granted write data each cycle.
- Undefined: stall behaviour as above. There is no forward datapath or hz_data register.

Test Plan:
- Reset: reset=0 for 3 cycles with both requesters valid -> req_ready=00, sram_write_enable=0, rsp_valid=00. After release, wr_ptr=rd_ptr=0.
- Write contention: both write (req0 @0x10=0xAAAA, req1 @0x20=0x5555) held valid -> grants alternate 0,1,0,1. SRAM sees 0x10 then 0x20 on consecutive cycles, one write per cycle.
- Parallel read/write: req0 writes 0x30=0x1234 while req1 reads 0x40 (preloaded 0xBEEF) -> both ready same cycle. Next cycle rsp_valid=10b (bit 1 set), rsp_data=0xBEEF.
- RAW stall: req0 writes 0x50=0xCAFE at cycle t; req1 reads 0x50 from cycle t:
  - Default: req_ready[1]=0 in t and t+1, accepted t+2, rsp_data=0xCAFE at t+3, never X.
  - With SRAM_ARB_FWD_EN: accepted at t, rsp_data=0xCAFE at t+1.
- Read streaming: req0 reads 0x0..0x7 back-to-back, no writes -> 8 accepts in 8 cycles. rsp_valid[0] high 8 consecutive cycles with data in address order.
- Reset mid-read: read accepted at t, reset=0 at t+1 -> rsp_valid stays 00. A subsequent read after release behaves normally.
